// File: rtl/blocking_vs_nonblocking.sv
// Go-triggered sequential WIDTH x WIDTH unsigned shift-add multiplier.
// Optional feature: define BVN_ACCUMULATE_EN for a running multiply-accumulate on Y with sticky ovf.
module blocking_vs_nonblocking #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 go,
    output logic [2*WIDTH-1:0]   Y,
    output logic                 busy,
`ifdef BVN_ACCUMULATE_EN
    output logic                 ovf,
`endif
    output logic                 done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 go_q;
    logic                 go_rise;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    assign go_rise = go & ~go_q;
    assign busy    = (state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go_rise) state_next = CALC;
            CALC: if (cnt == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef BVN_ACCUMULATE_EN
    // One extra bit catches the carry-out that feeds the sticky overflow flag.
    logic [2*WIDTH:0] mac_sum;
    assign mac_sum = {1'b0, Y} + {1'b0, acc};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Y      <= '0;
            done   <= 1'b0;
`ifdef BVN_ACCUMULATE_EN
            ovf    <= 1'b0;
`endif
        end else begin
            go_q <= go;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_rise) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    // acc already holds the product including the last partial add.
`ifdef BVN_ACCUMULATE_EN
                    Y <= mac_sum[2*WIDTH-1:0];
                    if (mac_sum[2*WIDTH]) begin
                        ovf <= 1'b1;
                    end
`else
                    Y <= acc;
`endif
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blocking_vs_nonblocking.sv
// Scoreboard bench for blocking_vs_nonblocking: stimulus pushes expected Y, a monitor pops on done.
// Build with BVN_ACCUMULATE_EN defined to exercise the multiply-accumulate variant.
module tb_blocking_vs_nonblocking;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       go;
    logic [7:0] Y;
    logic       busy;
    logic       done;
`ifdef BVN_ACCUMULATE_EN
    logic       ovf;
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    blocking_vs_nonblocking #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .go   (go),
        .Y    (Y),
        .busy (busy),
`ifdef BVN_ACCUMULATE_EN
        .ovf  (ovf),
`endif
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] plain, input logic [7:0] accum);
        return ACC ? accum : plain;
    endfunction

    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input bit push,
                                  input logic [7:0] exp_y);
        @(negedge clk);
        A  = a;
        B  = b;
        go = 1'b1;
        if (push) sb.push_back(exp_y);
    endtask

    task automatic drop_go();
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
    endtask

    // Bounded wait for done; reports negedges elapsed and busy cycles seen.
    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: no done within 30 cycles, expected done", name);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [7:0] exp_y;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1 with Y=%h, expected no done", Y);
                end else begin
                    exp_y = sb.pop_front();
                    check_output("Y_on_done", {8'h00, Y}, {8'h00, exp_y});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int lat;
        int bc;
        rst = 1'b1;
        go  = 1'b0;
        A   = '0;
        B   = '0;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_Y", {8'h00, Y}, 16'h0000);
        check_output("reset_busy", {15'h0, busy}, 16'h0000);
        check_output("reset_done", {15'h0, done}, 16'h0000);

        $display("[TB] first op 1*3, latency and busy width");
        apply_stimulus(4'd1, 4'd3, 1'b1, 8'h03);
        wait_done("op1", lat, bc);
        check_output("latency", 16'(lat), 16'd6);
        check_output("busy_cycles", 16'(bc), 16'd4);
        @(negedge clk);
        check_output("done_one_cycle", {15'h0, done}, 16'h0000);

        drop_go();
        apply_stimulus(4'd1, 4'd3, 1'b1, pick(8'h03, 8'h06));
        wait_done("op2", lat, bc);
        drop_go();

        $display("[TB] boundary operands");
        apply_stimulus(4'd15, 4'd15, 1'b1, pick(8'hE1, 8'hE7));
        wait_done("op_ff", lat, bc);
        drop_go();
        apply_stimulus(4'd0, 4'd9, 1'b1, pick(8'h00, 8'hE7));
        wait_done("op_a0", lat, bc);
        drop_go();
        apply_stimulus(4'd9, 4'd0, 1'b1, pick(8'h00, 8'hE7));
        wait_done("op_b0", lat, bc);
        drop_go();
`ifdef BVN_ACCUMULATE_EN
        check_output("ovf_clear", {15'h0, ovf}, 16'h0000);
`endif

        $display("[TB] operand change and extra edge during CALC");
        apply_stimulus(4'd5, 4'd6, 1'b1, pick(8'h1E, 8'h05));
        idle_cycles(2);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        A  = 4'd2;
        B  = 4'd2;
        wait_done("op_chg", lat, bc);
        idle_cycles(10);
        check_output("no_retrigger_busy", {15'h0, busy}, 16'h0000);
`ifdef BVN_ACCUMULATE_EN
        check_output("ovf_set", {15'h0, ovf}, 16'h0001);
`endif
        drop_go();

        $display("[TB] go held high across many cycles");
        apply_stimulus(4'd3, 4'd4, 1'b1, pick(8'h0C, 8'h11));
        wait_done("op_hold", lat, bc);
        idle_cycles(20);
        check_output("hold_Y", {8'h00, Y}, {8'h00, pick(8'h0C, 8'h11)});
        drop_go();

        $display("[TB] reset during CALC");
        apply_stimulus(4'd7, 4'd7, 1'b0, 8'h00);
        idle_cycles(2);
        #2 rst = 1'b1;
        #1;
        check_output("midreset_Y", {8'h00, Y}, 16'h0000);
        check_output("midreset_busy", {15'h0, busy}, 16'h0000);
        check_output("midreset_done", {15'h0, done}, 16'h0000);
`ifdef BVN_ACCUMULATE_EN
        check_output("midreset_ovf", {15'h0, ovf}, 16'h0000);
`endif
        go = 1'b0;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(12);

        $display("[TB] go high through reset release");
        @(negedge clk);
        rst = 1'b1;
        go  = 1'b1;
        A   = 4'd2;
        B   = 4'd5;
        sb.push_back(8'h0A);
        idle_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check_output("start_after_reset", {15'h0, busy}, 16'h0001);
        wait_done("op_rel", lat, bc);
        drop_go();

        $display("[TB] repeated 15*15");
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        apply_stimulus(4'd15, 4'd15, 1'b1, 8'hE1);
        wait_done("rep1", lat, bc);
        drop_go();
        apply_stimulus(4'd15, 4'd15, 1'b1, pick(8'hE1, 8'hC2));
        wait_done("rep2", lat, bc);
        drop_go();
`ifdef BVN_ACCUMULATE_EN
        idle_cycles(5);
        check_output("ovf_sticky", {15'h0, ovf}, 16'h0001);
`endif
        idle_cycles(5);
        check_output("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/blocking_vs_nonblocking.md
Name: blocking_vs_nonblocking

Overview:
Go-triggered sequential 4x4 unsigned multiplier. It captures operands A and B on a rising edge of go and computes Y = A*B with a 4-cycle shift-add datapath. Y holds the last result until the next operation completes. Used as a small datapath block and as a register-transfer teaching/verification vehicle.

Parameters:
- WIDTH, 4: operand width. Y is 2*WIDTH bits; CALC lasts WIDTH cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- A  in  WIDTH  multiplicand, sampled at start
- B  in  WIDTH  multiplier, sampled at start
- go  in  1  start request; a rising edge is the trigger; level is don't-care
- Y  out  2*WIDTH  result register
- busy  out  1  high while state is CALC
- done  out  1  one-cycle pulse when Y is updated

Behaviour:
- Single clock domain; every flop is reset asynchronously by rst=1.
- Reset values: Y=0, busy=0, done=0, state=IDLE, go_q=0, internal accumulator, operand registers and counter = 0.
- Edge detect: go_q <= go on every clock; go_rise = go & ~go_q. Because go_q resets to 0, go held high at reset release produces go_rise on the first clock after release.
- States: IDLE, CALC, DONE.
- IDLE:
  - On go_rise: mcand <= {WIDTH zeros, A}, mplier <= B, acc <= 0, cnt <= 0, state -> CALC.
  - Otherwise remain in IDLE.
- CALC, WIDTH cycles:
  - Each cycle: if mplier[0], acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - After the cycle with cnt = WIDTH-1: Y <= final acc (including that cycle's add), state -> DONE.
- DONE: done=1 for exactly this one cycle; state -> IDLE.
- busy = (state == CALC); combinational from the state register.
- Latency: go_rise sampled at clock edge N; Y valid and done=1 after edge N+WIDTH+1, which is edge N+5 for WIDTH=4. The next start is accepted no earlier than edge N+WIDTH+2.
- Arithmetic: unsigned. Accumulator is 2*WIDTH bits, so no overflow is possible; max 15*15 = 225 = 8'hE1.
- go_rise during CALC or DONE: ignored and not queued. go_q still tracks go, so an edge that is already high when IDLE is re-entered does not retrigger.
- A and B changing during CALC have no effect; operands are latched.
- Y changes only on completion or reset. It holds its value indefinitely otherwise.
- Reset asserted mid-operation: immediate return to reset values, Y=0, and no done pulse.

Optional Feature:
- Macro: BVN_ACCUMULATE_EN.
- Defined:
  - On completion, Y <= Y + product, a running multiply-accumulate modulo 2^(2*WIDTH).
  - Y is cleared only by reset.
  - Adds output ovf, 1 bit, which is sticky: it sets on carry-out of that add and clears only on reset.
- Not defined: Y <= product and no ovf port exists.

Test Plan:
- Reset, then A=1, B=3, go 0->1 -> 5 clocks later Y=8'h03, done pulses once, busy high for exactly 4 cycles.
- Drop go, then raise go again with A=1, B=3 unchanged -> Y=8'h03, done pulses. With BVN_ACCUMULATE_EN, Y=8'h06.
- A=15, B=15, start -> Y=8'hE1. Then A=0, B=9, start -> Y=8'h00. Also A=9, B=0 -> Y=0.
- Start with A=5, B=6, then toggle go and change A=2, B=2 during CALC -> Y=8'h1E; exactly one done pulse; the extra edge is ignored.
- Hold go high continuously across several operations -> only one operation runs. Assert rst during CALC -> Y=0, busy=0, done=0 immediately; no done pulse follows. Hold go high through reset release -> an operation starts on the first clock.
- BVN_ACCUMULATE_EN: repeated A=15, B=15 -> Y sequence E1, C2 with ovf=1 set and remaining set thereafter.
